// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: 2-bit counter plus target per entry, with a mispredict
// redirect to EX and saturating resolution statistics.
module branch_predictor #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned PC_W    = 32,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PC_W-1:0]  if_pc,
    output logic             pred_taken,
    output logic [PC_W-1:0]  pred_target,
    input  logic             ex_valid,
    input  logic [PC_W-1:0]  ex_pc,
    input  logic             ex_taken,
    input  logic [PC_W-1:0]  ex_target,
    input  logic             ex_pred_taken,
    input  logic [PC_W-1:0]  ex_pred_target,
    output logic             mispredict,
    output logic [PC_W-1:0]  redirect_pc,
    input  logic             stat_clear,
    output logic [CNT_W-1:0] stat_total,
    output logic [CNT_W-1:0] stat_taken,
    output logic [CNT_W-1:0] stat_mispredict
);

    localparam int unsigned IDX   = $clog2(ENTRIES);
    localparam int unsigned TAG_W = PC_W - IDX - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [PC_W-1:0]    target_q [ENTRIES];
    logic [1:0]         cnt_q    [ENTRIES];

    logic [IDX-1:0]   if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             ex_hit;
    logic [1:0]       cnt_next;

    logic [CNT_W-1:0] stat_total_q, stat_taken_q, stat_mis_q;
    logic [CNT_W-1:0] stat_total_d, stat_taken_d, stat_mis_d;

    assign if_idx = if_pc[IDX+1:2];
    assign if_tag = if_pc[PC_W-1:IDX+2];
    assign ex_idx = ex_pc[IDX+1:2];
    assign ex_tag = ex_pc[PC_W-1:IDX+2];
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    // Lookup sees registered state only, so a same-cycle update is not forwarded.
    always_comb begin
        pred_taken  = valid_q[if_idx] && (tag_q[if_idx] == if_tag) && cnt_q[if_idx][1];
        pred_target = pred_taken ? target_q[if_idx] : '0;
    end

    always_comb begin
        cnt_next = cnt_q[ex_idx];
        if (ex_taken) begin
            if (cnt_q[ex_idx] != 2'd3) cnt_next = cnt_q[ex_idx] + 2'd1;
        end else begin
            if (cnt_q[ex_idx] != 2'd0) cnt_next = cnt_q[ex_idx] - 2'd1;
        end
    end

    always_comb begin
        mispredict  = ex_valid && ((ex_taken != ex_pred_taken) ||
                      (ex_taken && ex_pred_taken && (ex_target != ex_pred_target)));
        redirect_pc = ex_taken ? ex_target : ex_pc + PC_W'(4);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= 2'd1;
            end
        end else if (ex_valid) begin
            if (ex_hit) begin
                cnt_q[ex_idx] <= cnt_next;
                if (ex_taken) target_q[ex_idx] <= ex_target;
            end else if (ex_taken) begin
                valid_q[ex_idx]  <= 1'b1;
                tag_q[ex_idx]    <= ex_tag;
                target_q[ex_idx] <= ex_target;
                cnt_q[ex_idx]    <= 2'd2;
            end
        end
    end

    always_comb begin
        stat_total_d = stat_total_q;
        stat_taken_d = stat_taken_q;
        stat_mis_d   = stat_mis_q;
        if (ex_valid) begin
            if (stat_total_q != '1) stat_total_d = stat_total_q + CNT_W'(1);
            if (ex_taken && stat_taken_q != '1) stat_taken_d = stat_taken_q + CNT_W'(1);
            if (mispredict && stat_mis_q != '1) stat_mis_d = stat_mis_q + CNT_W'(1);
        end
        if (stat_clear) begin
            stat_total_d = '0;
            stat_taken_d = '0;
            stat_mis_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_total_q <= '0;
            stat_taken_q <= '0;
            stat_mis_q   <= '0;
        end else begin
            stat_total_q <= stat_total_d;
            stat_taken_q <= stat_taken_d;
            stat_mis_q   <= stat_mis_d;
        end
    end

    assign stat_total      = stat_total_q;
    assign stat_taken      = stat_taken_q;
    assign stat_mispredict = stat_mis_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_branch_predictor;

    localparam int KPRED = 0;
    localparam int KMIS  = 1;
    localparam int KEX   = 2;
    localparam int KSTAT = 3;

    typedef struct {
        int          kind;
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic        stat_clear;
    logic [3:0]  stat_total, stat_taken, stat_mispredict;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(16), .PC_W(32), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc), .stat_clear(stat_clear),
        .stat_total(stat_total), .stat_taken(stat_taken), .stat_mispredict(stat_mispredict)
    );

    // Monitor: outputs are settled at the falling edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t        e;
            logic [31:0] ga, gb, gc;
            e  = sb.pop_front();
            ga = '0;
            gb = '0;
            gc = '0;
            case (e.kind)
                KPRED: begin ga = {31'b0, pred_taken}; gb = pred_target; end
                KMIS:  ga = {31'b0, mispredict};
                KEX:   begin ga = {31'b0, mispredict}; gb = redirect_pc; end
                default: begin
                    ga = {28'b0, stat_total};
                    gb = {28'b0, stat_taken};
                    gc = {28'b0, stat_mispredict};
                end
            endcase
            checks++;
            if (ga !== e.a || gb !== e.b || gc !== e.c) begin
                errors++;
                $display("FAIL %s: got %h/%h/%h expected %h/%h/%h",
                         e.name, ga, gb, gc, e.a, e.b, e.c);
            end
        end
    end

    task automatic push(input int k, input string n, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] c);
        exp_t e;
        e.kind = k; e.name = n; e.a = a; e.b = b; e.c = c;
        sb.push_back(e);
    endtask

    task automatic exp_pred(input string n, input logic t, input logic [31:0] tgt);
        push(KPRED, n, {31'b0, t}, tgt, 32'h0);
    endtask

    task automatic exp_ex(input string n, input logic m, input logic [31:0] r);
        push(KEX, n, {31'b0, m}, r, 32'h0);
    endtask

    task automatic exp_stat(input string n, input int t, input int tk, input int m);
        push(KSTAT, n, t, tk, m);
    endtask

    task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt);
        ex_valid = 1'b1; ex_pc = pc; ex_taken = tk; ex_target = tgt;
        ex_pred_taken = ptk; ex_pred_target = ptgt;
    endtask

    task automatic idle();
        ex_valid = 1'b0; ex_pc = '0; ex_taken = 1'b0; ex_target = '0;
        ex_pred_taken = 1'b0; ex_pred_target = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; stat_clear = 1'b0; if_pc = '0;
        idle();
        tick();
        tick();
        reset = 1'b1;

        // Post-reset state.
        if_pc = 32'h1010;
        exp_pred("reset_pred", 1'b0, 32'h0);
        push(KMIS, "reset_mis", 32'h0, 32'h0, 32'h0);
        exp_stat("reset_stat", 0, 0, 0);
        tick();

        // Cold miss, same-cycle lookup returns pre-update contents.
        resolve(32'h1010, 1'b1, 32'h1018, 1'b0, 32'h0);
        exp_ex("cold_ex", 1'b1, 32'h1018);
        exp_pred("cold_same_cycle", 1'b0, 32'h0);
        tick();
        idle();
        exp_pred("cold_alloc", 1'b1, 32'h1018);
        exp_stat("cold_stat", 1, 1, 1);
        tick();

        // Saturate at 3, then two not-taken.
        for (int i = 0; i < 3; i++) begin
            resolve(32'h1010, 1'b1, 32'h1018, 1'b1, 32'h1018);
            if (i == 0) exp_ex("hit_correct", 1'b0, 32'h1018);
            tick();
        end
        resolve(32'h1010, 1'b0, 32'h1018, 1'b1, 32'h1018);
        exp_ex("nt1_ex", 1'b1, 32'h1014);
        tick();
        idle();
        exp_pred("sat_3to2", 1'b1, 32'h1018);
        tick();
        resolve(32'h1010, 1'b0, 32'h1018, 1'b1, 32'h1018);
        tick();
        idle();
        exp_pred("sat_2to1", 1'b0, 32'h0);
        exp_stat("sat_stat", 6, 4, 3);
        tick();

        // Not-taken miss: no allocation.
        resolve(32'h1048, 1'b0, 32'h2222, 1'b0, 32'h0);
        exp_ex("ntmiss_ex", 1'b0, 32'h104C);
        tick();
        idle();
        if_pc = 32'h1048;
        exp_pred("ntmiss_noalloc", 1'b0, 32'h0);
        exp_stat("ntmiss_stat", 7, 4, 3);
        tick();

        // Re-arm 0x1010 (counter 1->2), then alias 0x1050 onto index 4.
        resolve(32'h1010, 1'b1, 32'h1018, 1'b0, 32'h0);
        tick();
        idle();
        if_pc = 32'h1010;
        exp_pred("rearm", 1'b1, 32'h1018);
        tick();
        resolve(32'h1050, 1'b1, 32'h1060, 1'b0, 32'h0);
        exp_ex("alias_ex", 1'b1, 32'h1060);
        tick();
        idle();
        exp_pred("alias_old", 1'b0, 32'h0);
        exp_stat("alias_stat", 9, 6, 5);
        tick();
        if_pc = 32'h1050;
        exp_pred("alias_new", 1'b1, 32'h1060);
        tick();

        // Wrong target, then correct target on the same branch.
        resolve(32'h3000, 1'b1, 32'h2004, 1'b1, 32'h2000);
        exp_ex("wrong_tgt", 1'b1, 32'h2004);
        tick();
        resolve(32'h3000, 1'b1, 32'h2004, 1'b1, 32'h2004);
        exp_ex("right_tgt", 1'b0, 32'h2004);
        exp_stat("wrong_tgt_stat", 10, 7, 6);
        tick();
        idle();
        exp_stat("right_tgt_stat", 11, 8, 6);
        tick();

        // Statistics saturation.
        for (int i = 0; i < 17; i++) begin
            resolve(32'h3000, 1'b1, 32'h2004, 1'b1, 32'h2004);
            tick();
        end
        idle();
        exp_stat("stat_sat", 15, 15, 6);
        tick();

        // Clear overrides a same-cycle increment.
        resolve(32'h3000, 1'b1, 32'h2004, 1'b0, 32'h0);
        stat_clear = 1'b1;
        tick();
        stat_clear = 1'b0;
        resolve(32'h3000, 1'b1, 32'h2004, 1'b1, 32'h2004);
        exp_stat("stat_clear", 0, 0, 0);
        tick();
        idle();
        exp_stat("after_clear", 1, 1, 0);
        tick();

        // Reset mid-sequence discards an in-flight update.
        reset = 1'b0;
        resolve(32'h1050, 1'b1, 32'h1070, 1'b0, 32'h0);
        stat_clear = 1'b1;
        tick();
        reset = 1'b1;
        stat_clear = 1'b0;
        idle();
        if_pc = 32'h3000;
        exp_stat("mid_reset_stat", 0, 0, 0);
        exp_pred("mid_reset_3000", 1'b0, 32'h0);
        push(KMIS, "mid_reset_mis", 32'h0, 32'h0, 32'h0);
        tick();
        if_pc = 32'h1050;
        exp_pred("mid_reset_1050", 1'b0, 32'h0);
        tick();

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ENTRIES, default 16, number of predictor entries; power of two, 2..256.
REQ-002 Parameter PC_W, default 32, program-counter width.
REQ-003 Parameter CNT_W, default 32, width of each statistics counter.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 if_pc  in  PC_W  fetch-stage PC being looked up.
REQ-007 pred_taken  out  1  prediction for if_pc: 1 = taken.
REQ-008 pred_target  out  PC_W  predicted target for if_pc; 0 when pred_taken=0.
REQ-009 ex_valid  in  1  a conditional branch resolves in EX this cycle.
REQ-010 ex_pc  in  PC_W  PC of the resolving branch.
REQ-011 ex_taken  in  1  actual branch outcome.
REQ-012 ex_target  in  PC_W  actual branch target.
REQ-013 ex_pred_taken  in  1  prediction made for this branch at fetch, piped to EX.
REQ-014 ex_pred_target  in  PC_W  target predicted at fetch, piped to EX.
REQ-015 mispredict  out  1  flush request for younger instructions.
REQ-016 redirect_pc  out  PC_W  correct next PC when mispredict=1.
REQ-017 stat_clear  in  1  zeroes all statistics counters.
REQ-018 stat_total, stat_taken, stat_mispredict  out  CNT_W each  resolved, taken and mispredicted branch counts.

Function
REQ-019 Index = pc[IDX+1:2], IDX = log2(ENTRIES); tag = pc[PC_W-1:IDX+2].
REQ-020 Each entry holds: valid bit, tag, target (PC_W), 2-bit saturating counter.
REQ-021 Lookup is combinational from registered table state: pred_taken = valid & tag match & counter[1].
REQ-022 Update occurs only on a rising edge with ex_valid=1; it is visible to lookup the following cycle (1-cycle latency).
REQ-023 Hit on ex_pc: counter increments on taken and decrements on not-taken, saturating at 3 and 0; target is overwritten with ex_target only when taken.
REQ-024 Miss, taken: allocate by overwriting the indexed entry: valid=1, tag, target=ex_target, counter=2 (weakly taken).
REQ-025 Miss, not taken: table unchanged.
REQ-026 Same-cycle lookup and update at the same index: lookup returns pre-update contents.
REQ-027 mispredict = ex_valid & ((ex_taken != ex_pred_taken) | (ex_taken & ex_pred_taken & (ex_target != ex_pred_target))); combinational.
REQ-028 redirect_pc = ex_taken ? ex_target : ex_pc + 4 (modulo 2^PC_W); this value is driven whenever ex_valid=1.
REQ-029 When ex_valid=1: stat_total increments; stat_taken increments if ex_taken; stat_mispredict increments if mispredict.
REQ-030 Statistics counters saturate at all-ones and never wrap.
REQ-031 stat_clear=1 forces all three counters to 0 on that edge, overriding a same-cycle increment.
REQ-032 ex_valid=0 leaves table and statistics unchanged; mispredict=0.

Reset
REQ-033 reset=0 at a rising edge clears every valid bit, sets every counter to 1 (weakly not-taken), zeroes targets, tags and all statistics.
REQ-034 Reset overrides same-cycle ex_valid and stat_clear; an update in flight is discarded.
REQ-035 Cycle after reset: pred_taken=0 and pred_target=0 for any if_pc; mispredict=0 whenever ex_valid=0.

Verification
REQ-036 Cold miss: after reset, resolve ex_pc=0x1010 taken, ex_target=0x1018, ex_pred_taken=0 -> mispredict=1, redirect_pc=0x1018; next cycle if_pc=0x1010 gives pred_taken=1, pred_target=0x1018.
REQ-037 Saturation: resolve 0x1010 taken 3 more times, then not-taken once -> pred_taken stays 1 (counter 3->2); second not-taken -> pred_taken=0.
REQ-038 Not-taken miss: resolve 0x1048 not-taken, ex_pred_taken=0 -> mispredict=0, redirect_pc=0x104C, no allocation, stat_taken unchanged.
REQ-039 Alias, ENTRIES=16: after 0x1010 is allocated, resolve 0x1050 taken to 0x1060 -> entry replaced; if_pc=0x1010 then gives pred_taken=0.
REQ-040 Wrong target: ex_pred_taken=1, ex_pred_target=0x2000, ex_taken=1, ex_target=0x2004 -> mispredict=1, redirect_pc=0x2004, stat_mispredict +1.
REQ-041 Stats: CNT_W=4, run 17 taken resolutions -> stat_total=0xF held; stat_clear with ex_valid=1 on the same edge -> all counters 0; reset mid-sequence -> all counters 0 and pred_taken=0.
